// File: rtl/xor_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial XOR sequencer.
// Holds opcode constants (also consumed by microcode ROM generation),
// FSM state encodings, datapath widths, the request payload struct and
// the effective-B helper.
package xor_seq_defs;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned ST_W   = 2;

  localparam logic [OP_W-1:0] OP_XOR  = 2'b00;
  localparam logic [OP_W-1:0] OP_XNOR = 2'b01;
  localparam logic [OP_W-1:0] OP_NOT  = 2'b10;
  localparam logic [OP_W-1:0] OP_CMP  = 2'b11;

  localparam logic [ST_W-1:0] ST_IDLE = 2'b00;
  localparam logic [ST_W-1:0] ST_LO   = 2'b01;
  localparam logic [ST_W-1:0] ST_HI   = 2'b10;
  localparam logic [ST_W-1:0] ST_DONE = 2'b11;

  // Request payload sampled on accept
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } req_t;

  // B operand fed to the XOR chip so that every op reduces to a ^ b'
  function automatic logic [DATA_W-1:0] eff_b(input logic [OP_W-1:0] op,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      OP_XNOR: r = ~b;
      OP_NOT:  r = {DATA_W{1'b1}};
      default: r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/xor_seq_ctrl_if.sv
// Request/result bus between microcode control and the XOR sequencer.
//   start : request strobe (master -> slave)
//   req   : op / a / b payload (master -> slave)
//   ready : sequencer idle (slave -> master)
//   valid : one-cycle result pulse (slave -> master)
//   y     : 8-bit result (slave -> master)
//   zero  : XOR-result-is-zero flag (slave -> master)
interface xor_seq_ctrl_if;
  import xor_seq_defs::*;

  logic              start;
  req_t              req;
  logic              ready;
  logic              valid;
  logic [DATA_W-1:0] y;
  logic              zero;

  modport master (output start, req, input ready, valid, y, zero);
  modport slave  (input start, req, output ready, valid, y, zero);

endinterface

// File: rtl/xor_seq_ctrl_xor_86b.sv
// Model of the 4-bit 74xx86 bus-variant XOR chip.
//   a, b : 4-bit inputs
//   y    : 4-bit a ^ b
module xor_86b
  import xor_seq_defs::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic [NIB_W-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_seq_ctrl.sv
// Nibble-serial 8-bit XOR/XNOR/NOT/CMP sequencer around one xor_86b chip.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of xor_seq_ctrl_if (start/req in, ready/valid/y/zero out)
module xor_seq_ctrl
  import xor_seq_defs::*;
(
  input  logic           clk,
  input  logic           reset,
  xor_seq_ctrl_if.slave  bus
);

  logic [ST_W-1:0]   state;
  logic [ST_W-1:0]   state_d;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [NIB_W-1:0]  scratch_lo;
  logic [DATA_W-1:0] y_q;
  logic              zero_q;
  logic              valid_q;

  logic              accept;
  logic              lo_en;
  logic              hi_en;
  logic [NIB_W-1:0]  chip_a;
  logic [NIB_W-1:0]  chip_b;
  logic [NIB_W-1:0]  chip_y;
  logic [DATA_W-1:0] assembled;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Next state, chip nibble mux and load strobes; chip idles at 0
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    lo_en   = 1'b0;
    hi_en   = 1'b0;
    chip_a  = '0;
    chip_b  = '0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        chip_a  = a_q[NIB_W-1:0];
        chip_b  = b_q[NIB_W-1:0];
        lo_en   = 1'b1;
        state_d = ST_HI;
      end
      ST_HI: begin
        chip_a  = a_q[DATA_W-1:NIB_W];
        chip_b  = b_q[DATA_W-1:NIB_W];
        hi_en   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  xor_86b u_chip (
    .a (chip_a),
    .b (chip_b),
    .y (chip_y)
  );

  assign assembled = {chip_y, scratch_lo};

  // Operand, scratch and result registers; results land on HI->DONE so
  // they are visible for the whole DONE cycle alongside valid
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      scratch_lo <= '0;
      y_q        <= '0;
      zero_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= hi_en;
      if (accept) begin
        op_q <= bus.req.op;
        a_q  <= bus.req.a;
        b_q  <= eff_b(bus.req.op, bus.req.b);
      end
      if (lo_en) scratch_lo <= chip_y;
      if (hi_en) begin
        zero_q <= (assembled == '0);
        if (op_q != OP_CMP) y_q <= assembled;
      end
    end
  end

  assign bus.ready = (state == ST_IDLE);
  assign bus.valid = valid_q;
  assign bus.y     = y_q;
  assign bus.zero  = zero_q;

endmodule

// File: tb/tb_xor_seq_ctrl.sv
// Directed self-checking bench for xor_seq_ctrl.
module tb_xor_seq_ctrl;
  import xor_seq_defs::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  xor_seq_ctrl_if bus ();

  xor_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One op from IDLE: accept, LO, HI, DONE, back to IDLE
  task automatic run_op(input string tag, input logic [1:0] op_i,
                        input logic [7:0] a_i, input logic [7:0] b_i,
                        input logic [7:0] ey, input logic ez);
    chk({tag, ".ready_pre"}, 8'(bus.ready), 8'h01);
    bus.start = 1'b1;
    bus.req   = req_t'{op: op_i, a: a_i, b: b_i};
    tick();
    bus.start = 1'b0;
    bus.req   = req_t'{op: ~op_i, a: ~a_i, b: a_i};
    chk({tag, ".ready_lo"}, 8'(bus.ready), 8'h00);
    chk({tag, ".valid_lo"}, 8'(bus.valid), 8'h00);
    tick();
    chk({tag, ".ready_hi"}, 8'(bus.ready), 8'h00);
    chk({tag, ".valid_hi"}, 8'(bus.valid), 8'h00);
    tick();
    chk({tag, ".valid"}, 8'(bus.valid), 8'h01);
    chk({tag, ".ready_done"}, 8'(bus.ready), 8'h00);
    chk({tag, ".y"}, bus.y, ey);
    chk({tag, ".zero"}, 8'(bus.zero), 8'(ez));
    tick();
    chk({tag, ".valid_off"}, 8'(bus.valid), 8'h00);
    chk({tag, ".ready_post"}, 8'(bus.ready), 8'h01);
  endtask

  logic [1:0] bb_op [12];
  logic [7:0] bb_a  [12];
  logic [7:0] bb_b  [12];

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.req   = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      chk("idle.ready", 8'(bus.ready), 8'h01);
      chk("idle.valid", 8'(bus.valid), 8'h00);
      chk("idle.y", bus.y, 8'h00);
      chk("idle.zero", 8'(bus.zero), 8'h00);
      tick();
    end

    run_op("xor",  OP_XOR,  8'hA5, 8'h3C, 8'h99, 1'b0);
    run_op("xnor", OP_XNOR, 8'h0F, 8'hF0, 8'h00, 1'b1);
    run_op("not",  OP_NOT,  8'h5A, 8'hFF, 8'hA5, 1'b0);
    run_op("xor2", OP_XOR,  8'hA5, 8'h3C, 8'h99, 1'b0);
    run_op("cmp_eq", OP_CMP, 8'h42, 8'h42, 8'h99, 1'b1);
    run_op("cmp_ne", OP_CMP, 8'h42, 8'h43, 8'h99, 1'b0);

    // Back-to-back: start high for 9 edges, operands change every cycle.
    // Accepts at edges 0, 4, 8: 00^0F=0F, XNOR 44,0F -> 44^F0=B4, 88^0F=87.
    for (int k = 0; k < 12; k++) begin
      bb_op[k] = (k % 2 == 1) ? OP_NOT : OP_XOR;
      bb_a[k]  = 8'(k * 17);
      bb_b[k]  = 8'h0F;
    end
    bb_op[4] = OP_XNOR;
    for (int k = 0; k < 12; k++) begin
      bus.start = (k < 9);
      bus.req   = req_t'{op: bb_op[k], a: bb_a[k], b: bb_b[k]};
      tick();
      chk($sformatf("b2b.valid%0d", k), 8'(bus.valid),
          8'((k == 2) || (k == 6) || (k == 10)));
      chk($sformatf("b2b.ready%0d", k), 8'(bus.ready), 8'(k % 4 == 3));
      if (k == 2)  chk("b2b.y0", bus.y, 8'h0F);
      if (k == 6)  chk("b2b.y1", bus.y, 8'hB4);
      if (k == 10) chk("b2b.y2", bus.y, 8'h87);
    end
    bus.start = 1'b0;

    // Reset during HI discards the op
    bus.start = 1'b1;
    bus.req   = req_t'{op: OP_XOR, a: 8'hF0, b: 8'h0F};
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rst_hi.valid", 8'(bus.valid), 8'h00);
    chk("rst_hi.y", bus.y, 8'h00);
    chk("rst_hi.zero", 8'(bus.zero), 8'h00);
    chk("rst_hi.ready", 8'(bus.ready), 8'h01);
    reset = 1'b0;
    tick();
    chk("rst_hi.valid_after", 8'(bus.valid), 8'h00);
    run_op("after_rst", OP_XOR, 8'h12, 8'h34, 8'h26, 1'b0);

    // Reset and start together: request dropped
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.req   = req_t'{op: OP_XOR, a: 8'h01, b: 8'h01};
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    chk("rst_start.ready", 8'(bus.ready), 8'h01);
    tick();
    chk("rst_start.ready2", 8'(bus.ready), 8'h01);
    tick();
    tick();
    chk("rst_start.valid", 8'(bus.valid), 8'h00);
    chk("rst_start.y", bus.y, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor_seq_ctrl.md
# xor_seq_ctrl

Nibble-serial sequencer that performs 8-bit XOR-family operations on the CPU's existing 4-bit 74xx86 bus-variant XOR chip model (`xor_86b`). It latches two 8-bit operands and an opcode, drives the low then the high nibble through the single chip instance, and assembles the result. It then presents the 8-bit result with a zero flag and a one-cycle valid pulse. It sits between the microcode control word and the ALU result bus, replacing a second XOR package.

## Interface
Parameters:
- none; widths are fixed by the chip: 4-bit datapath, 8-bit operands.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only on a rising edge where `ready`=1.
- `op`  in  2  operation, sampled with `start`: 00 XOR, 01 XNOR, 10 NOT (y=~a), 11 CMP.
- `a`  in  8  operand A, sampled with `start`.
- `b`  in  8  operand B, sampled with `start`; ignored for NOT.
- `ready`  out  1  high in IDLE only; combinational from state.
- `valid`  out  1  one-cycle pulse when result and flag are updated.
- `y`  out  8  result register; holds until the next non-CMP completion.
- `zero`  out  1  flag register; 1 when the completed op's 8-bit XOR result is 0x00.

## Operation
- FSM states: IDLE, LO, HI, DONE.
- IDLE: `ready`=1. `start`=1 latches `a`, `b`, `op` into operand registers, then goes to LO. Otherwise stays in IDLE.
- Effective B operand: `b` for XOR and CMP, `~b` for XNOR, 0xFF for NOT. It is computed once at accept and stored.
- LO: chip inputs are A[3:0] and B'[3:0]. The chip output is captured into the low nibble of a scratch register. Next state HI.
- HI: chip inputs are A[7:4] and B'[7:4]. The full 8-bit scratch value is assembled and the next state is DONE.
- DONE: `valid`=1. `zero` is updated from the scratch value. `y` is loaded from scratch except for CMP, where `y` keeps its prior value. Next state IDLE.
- The chip inputs are driven to 0 in IDLE and DONE, so its output is never X on the bus.
- `start` outside IDLE is ignored, not queued.
- Operand inputs may change freely after the accept edge.

## Timing
- Reset values: state IDLE, `ready`=1, `valid`=0, `y`=0x00, `zero`=0, scratch and operand registers 0.
- Accept on edge E0. LO occupies the cycle after E0, HI the next cycle, and DONE the next.
- `valid`, `y` and `zero` are visible in the third cycle after E0.
- `ready` returns high one cycle later. The earliest next accept is edge E0+4, giving throughput of one op per 4 cycles.
- `start` held continuously issues back-to-back ops every 4 cycles, re-sampling operands at each accept.
- Reset asserted in any state takes effect at that edge: IDLE, outputs at reset values, no `valid` pulse, in-flight op discarded.
- Reset and `start` in the same cycle: reset wins and the request is dropped.
- No X may appear on `y`, `zero`, `valid`, `ready` at any cycle after the first reset edge.

## Structure
- Shared include/package `xor_seq_defs`: opcode constants (OP_XOR, OP_XNOR, OP_NOT, OP_CMP) and state encodings. Microcode ROM generation reuses the opcodes.
- One sub-module: the existing `xor_86b` instance, fed by a nibble mux (A_lo/A_hi, B'_lo/B'_hi). There is no other hierarchy.
- Remaining logic stays in one module: FSM, operand/B' registers, scratch nibble registers, output registers.

## Test plan
- Reset then idle: after reset, `ready`=1, `valid`=0, `y`=0x00, `zero`=0, and none of them are X for 10 cycles.
- XOR: start with op=00, a=0xA5, b=0x3C. Expect `valid` exactly 3 cycles after accept, `y`=0x99, `zero`=0, and `ready` low for 3 cycles.
- XNOR and NOT: op=01, a=0x0F, b=0xF0 gives `y`=0x00, `zero`=1. Then op=10, a=0x5A, b=0xFF gives `y`=0xA5, `zero`=0.
- CMP preserves y: after the XOR above (y=0x99), run op=11, a=0x42, b=0x42. Expect `zero`=1 and `y` still 0x99. Then op=11, a=0x42, b=0x43 gives `zero`=0.
- Busy and back-to-back: start held high for 9 cycles with changing operands gives accepts at cycles 0 and 4 only (with a third at cycle 8 if start is still high then). Pulses on cycles 1–3 and 5–7 are ignored, and each result matches the operands present at its accept edge.
- Reset mid-op: assert reset during the HI state gives no `valid` pulse, `y`=0x00, and `ready`=1 the next cycle. A fresh op afterwards completes correctly.
